// File: rtl/cpu_pkg.sv
// Shared encodings for the 8-bit accumulator CPU: ALU ops, ACC sources and opcodes.
package cpu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0001;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_NOR = 4'b0011;
    localparam logic [3:0] ALU_SHL = 4'b1011;
    localparam logic [3:0] ALU_SHR = 4'b1100;

    localparam logic [1:0] ACC_SRC_ALU = 2'b00;
    localparam logic [1:0] ACC_SRC_REG = 2'b10;
    localparam logic [1:0] ACC_SRC_IMM = 2'b11;

    // Opcodes live in IR[7:4]; IR[3:0] is the register index or immediate.
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_NOR = 4'h3;
    localparam logic [3:0] OP_ST  = 4'h5;
    localparam logic [3:0] OP_BR  = 4'h7;
    localparam logic [3:0] OP_SHL = 4'hB;
    localparam logic [3:0] OP_SHR = 4'hC;
    localparam logic [3:0] OP_LDI = 4'hD;
    localparam logic [3:0] OP_LDR = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

endpackage

// File: rtl/alu8.sv
// Combinational ALU: A = register operand, B = accumulator; carry is meaningful for ADD/SUB/shifts.
module alu8
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        op,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (op)
            ALU_ADD: {carry, result} = {1'b0, a} + {1'b0, b};
            // Top bit of the widened difference is the borrow (a < b).
            ALU_SUB: {carry, result} = {1'b0, a} - {1'b0, b};
            ALU_NOR: result = ~(a | b);
            ALU_SHL: begin
                result = {b[DATA_W-2:0], 1'b0};
                carry  = b[DATA_W-1];
            end
            ALU_SHR: begin
                result = {1'b0, b[DATA_W-1:1]};
                carry  = b[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/datapath_core.sv
// Execution datapath: PC, IR, ACC, register file, ALU and retired-instruction counter.
// Optional registered carry flag output flagC when DATAPATH_CARRY_EN is defined.
module datapath_core
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              loadIR,
    input  logic              incPC,
    input  logic              loadPC,
    input  logic              loadAcc,
    input  logic              loadReg,
    input  logic              selPC,
    input  logic [1:0]        selACC,
    input  logic [3:0]        aluOp,
    input  logic              halt,
    input  logic [7:0]        imemData,
    output logic [ADDR_W-1:0] imemAddr,
    output logic [7:0]        instr,
    output logic              flagZ,
    output logic              flagN,
`ifdef DATAPATH_CARRY_EN
    output logic              flagC,
`endif
    output logic [DATA_W-1:0] accOut,
    output logic [CNT_W-1:0]  instrCount
);

    logic [ADDR_W-1:0] pc_q;
    logic [7:0]        ir_q;
    logic [DATA_W-1:0] acc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] rf_q [NUM_REGS];

    logic [3:0]        rf_idx;
    logic [DATA_W-1:0] rf_rd;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic [DATA_W-1:0] acc_d;
    logic              acc_we;
    logic [ADDR_W-1:0] br_target;

    assign rf_idx = ir_q[3:0];
    assign rf_rd  = rf_q[rf_idx];

    alu8 #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a      (rf_rd),
        .b      (acc_q),
        .op     (aluOp),
        .result (alu_result),
        .carry  (alu_carry)
    );

    always_comb begin
        acc_d  = acc_q;
        acc_we = 1'b0;
        case (selACC)
            ACC_SRC_ALU: begin
                acc_d  = alu_result;
                acc_we = loadAcc;
            end
            ACC_SRC_REG: begin
                acc_d  = rf_rd;
                acc_we = loadAcc;
            end
            ACC_SRC_IMM: begin
                acc_d  = {{(DATA_W-4){1'b0}}, ir_q[3:0]};
                acc_we = loadAcc;
            end
            default: ;
        endcase
    end

    always_comb begin
        br_target = {{(ADDR_W-4){1'b0}}, ir_q[3:0]};
        if (selPC) begin
            br_target = ADDR_W'(rf_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= '0;
            ir_q  <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (!halt) begin
            if (loadIR) begin
                ir_q  <= imemData;
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (loadPC) begin
                pc_q <= br_target;
            end else if (incPC) begin
                pc_q <= pc_q + ADDR_W'(1);
            end
            if (acc_we) begin
                acc_q <= acc_d;
            end
            // Non-blocking write stores the pre-edge ACC even if ACC also loads.
            if (loadReg) begin
                rf_q[rf_idx] <= acc_q;
            end
        end
    end

`ifdef DATAPATH_CARRY_EN
    logic carry_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            carry_q <= 1'b0;
        end else if (!halt && loadAcc && selACC == ACC_SRC_ALU) begin
            carry_q <= alu_carry;
        end
    end

    assign flagC = carry_q;
`else
    logic unused_carry;
    assign unused_carry = alu_carry;
`endif

    assign imemAddr   = pc_q;
    assign instr      = ir_q;
    assign accOut     = acc_q;
    assign flagZ      = (acc_q == '0);
    assign flagN      = acc_q[DATA_W-1];
    assign instrCount = cnt_q;

endmodule

// File: tb/tb_datapath_core.sv
// Directed self-checking bench for datapath_core; checks flagC when DATAPATH_CARRY_EN is defined.
module tb_datapath_core;

    logic        clk = 1'b0;
    logic        rst, loadIR, incPC, loadPC, loadAcc, loadReg, selPC, halt;
    logic [1:0]  selACC;
    logic [3:0]  aluOp;
    logic [7:0]  imemData;
    logic [7:0]  imemAddr, instr, accOut;
    logic        flagZ, flagN;
    logic [15:0] instrCount;
`ifdef DATAPATH_CARRY_EN
    logic        flagC;
`endif

    int vectors = 0;
    int errors  = 0;
    logic [15:0] exp_cnt = 16'd0;

    always #5 clk = ~clk;

    datapath_core dut (
        .clk        (clk),
        .rst        (rst),
        .loadIR     (loadIR),
        .incPC      (incPC),
        .loadPC     (loadPC),
        .loadAcc    (loadAcc),
        .loadReg    (loadReg),
        .selPC      (selPC),
        .selACC     (selACC),
        .aluOp      (aluOp),
        .halt       (halt),
        .imemData   (imemData),
        .imemAddr   (imemAddr),
        .instr      (instr),
        .flagZ      (flagZ),
        .flagN      (flagN),
`ifdef DATAPATH_CARRY_EN
        .flagC      (flagC),
`endif
        .accOut     (accOut),
        .instrCount (instrCount)
    );

    task automatic clear_strobes();
        rst = 0; loadIR = 0; incPC = 0; loadPC = 0; loadAcc = 0; loadReg = 0;
        selPC = 0; selACC = 2'b00; aluOp = 4'h0; halt = 0;
    endtask

    // One clock; outputs are sampled 1 time unit after the edge, then strobes drop.
    task automatic step();
        @(posedge clk);
        #1;
        clear_strobes();
    endtask

    task automatic fetch(input logic [7:0] v);
        imemData = v; loadIR = 1; step(); exp_cnt++;
    endtask

    task automatic alu(input logic [3:0] op);
        aluOp = op; selACC = 2'b00; loadAcc = 1; step();
    endtask

    task automatic load_imm();
        selACC = 2'b11; loadAcc = 1; step();
    endtask

    task automatic test_reset();
        clear_strobes(); imemData = 8'h00; rst = 1; step();
        vectors++; if (imemAddr !== 8'h00) begin errors++; $display("FAIL reset_pc got %h want 00", imemAddr); end
        vectors++; if (instr !== 8'h00) begin errors++; $display("FAIL reset_ir got %h want 00", instr); end
        vectors++; if (accOut !== 8'h00) begin errors++; $display("FAIL reset_acc got %h want 00", accOut); end
        vectors++; if (flagZ !== 1'b1 || flagN !== 1'b0) begin errors++; $display("FAIL reset_flags got Z%b N%b want Z1 N0", flagZ, flagN); end
        vectors++; if (instrCount !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", instrCount); end
    endtask

    task automatic test_fetch();
        imemData = 8'hD5; loadIR = 1; incPC = 1; step(); exp_cnt++;
        vectors++; if (instr !== 8'hD5) begin errors++; $display("FAIL fetch_ir got %h want d5", instr); end
        vectors++; if (imemAddr !== 8'h01) begin errors++; $display("FAIL fetch_pc got %h want 01", imemAddr); end
        vectors++; if (instrCount !== 16'd1) begin errors++; $display("FAIL fetch_cnt got %0d want 1", instrCount); end
    endtask

    task automatic test_imm_store_add();
        load_imm();
        vectors++; if (accOut !== 8'h05) begin errors++; $display("FAIL ldi got %h want 05", accOut); end
        fetch(8'h53); loadReg = 1; step();
        fetch(8'hD3); load_imm();
        fetch(8'h13); alu(4'b0001);
        vectors++; if (accOut !== 8'h08 || flagZ !== 1'b0) begin errors++; $display("FAIL add got %h Z%b want 08 Z0", accOut, flagZ); end
    endtask

    task automatic test_sub();
        fetch(8'h23); alu(4'b0010);
        vectors++; if (accOut !== 8'hFD || flagN !== 1'b1) begin errors++; $display("FAIL sub got %h N%b want fd N1", accOut, flagN); end
`ifdef DATAPATH_CARRY_EN
        vectors++; if (flagC !== 1'b1) begin errors++; $display("FAIL sub_borrow got %b want 1", flagC); end
`endif
        selACC = 2'b10; loadAcc = 1; step();
        vectors++; if (accOut !== 8'h05) begin errors++; $display("FAIL ldr_rf3 got %h want 05", accOut); end
    endtask

    task automatic test_shift();
        fetch(8'hD8); load_imm();
        fetch(8'hB0);
        for (int i = 0; i < 4; i++) alu(4'b1011);
        fetch(8'h51); loadReg = 1; step();
        fetch(8'hD1); load_imm();
        fetch(8'h11); alu(4'b0001);
        vectors++; if (accOut !== 8'h81) begin errors++; $display("FAIL build81 got %h want 81", accOut); end
        alu(4'b1011);
        vectors++; if (accOut !== 8'h02) begin errors++; $display("FAIL shl got %h want 02", accOut); end
`ifdef DATAPATH_CARRY_EN
        vectors++; if (flagC !== 1'b1) begin errors++; $display("FAIL shl_carry got %b want 1", flagC); end
`endif
        alu(4'b1100);
        vectors++; if (accOut !== 8'h01) begin errors++; $display("FAIL shr got %h want 01", accOut); end
`ifdef DATAPATH_CARRY_EN
        vectors++; if (flagC !== 1'b0) begin errors++; $display("FAIL shr_carry got %b want 0", flagC); end
`endif
        selACC = 2'b01; loadAcc = 1; step();
        vectors++; if (accOut !== 8'h01) begin errors++; $display("FAIL reserved_sel got %h want 01", accOut); end
        alu(4'b0000);
        vectors++; if (accOut !== 8'h00 || flagZ !== 1'b1) begin errors++; $display("FAIL bad_op got %h Z%b want 00 Z1", accOut, flagZ); end
    endtask

    task automatic test_pc();
        fetch(8'h30); alu(4'b0011);
        vectors++; if (accOut !== 8'hFF) begin errors++; $display("FAIL nor got %h want ff", accOut); end
        fetch(8'h54); loadReg = 1; selACC = 2'b11; loadAcc = 1; step();
        vectors++; if (accOut !== 8'h04) begin errors++; $display("FAIL st_and_ld got %h want 04", accOut); end
        fetch(8'h74); loadPC = 1; selPC = 1; step();
        vectors++; if (imemAddr !== 8'hFF) begin errors++; $display("FAIL br_reg_ff got %h want ff", imemAddr); end
        incPC = 1; step();
        vectors++; if (imemAddr !== 8'h00) begin errors++; $display("FAIL pc_wrap got %h want 00", imemAddr); end
        selACC = 2'b10; loadAcc = 1; step();
        vectors++; if (accOut !== 8'hFF) begin errors++; $display("FAIL rf4_old_acc got %h want ff", accOut); end
        fetch(8'h7A); loadPC = 1; incPC = 1; selPC = 0; step();
        vectors++; if (imemAddr !== 8'h0A) begin errors++; $display("FAIL br_imm_prio got %h want 0a", imemAddr); end
        fetch(8'hD4); load_imm();
        for (int i = 0; i < 4; i++) alu(4'b1011);
        fetch(8'h52); loadReg = 1; step();
        fetch(8'h72); loadPC = 1; selPC = 1; step();
        vectors++; if (imemAddr !== 8'h40) begin errors++; $display("FAIL br_rf2 got %h want 40", imemAddr); end
    endtask

    task automatic test_halt_reset();
        for (int c = 0; c < 5; c++) begin
            halt = 1; loadAcc = 1; selACC = 2'b11; loadReg = 1; loadIR = 1; imemData = 8'hEE;
            incPC = 1; loadPC = 1; aluOp = 4'b0001;
            step();
            vectors++;
            if (imemAddr !== 8'h40 || instr !== 8'h72 || accOut !== 8'h40 || instrCount !== exp_cnt) begin
                errors++;
                $display("FAIL halt_hold cyc%0d got pc%h ir%h acc%h cnt%0d want pc40 ir72 acc40 cnt%0d",
                         c, imemAddr, instr, accOut, instrCount, exp_cnt);
            end
        end
        rst = 1; halt = 1; loadAcc = 1; selACC = 2'b10; incPC = 1; step();
        vectors++;
        if (imemAddr !== 8'h00 || instr !== 8'h00 || accOut !== 8'h00 || instrCount !== 16'd0 || flagZ !== 1'b1) begin
            errors++;
            $display("FAIL halt_reset got pc%h ir%h acc%h cnt%0d Z%b want all 0 Z1",
                     imemAddr, instr, accOut, instrCount, flagZ);
        end
        fetch(8'hE2); selACC = 2'b10; loadAcc = 1; step();
        vectors++; if (accOut !== 8'h00) begin errors++; $display("FAIL rf_cleared got %h want 00", accOut); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_imm_store_add();
        test_sub();
        test_shift();
        test_pc();
        test_halt_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
